// File: rtl/sccomp_ahb_arbiter.sv
// -----------------------------------------------------------------------------
// sccomp_ahb_arbiter
//
// Two-master AHB-Lite arbiter. It sits in front of the shared address decoder
// and the slave bus. M0 is the CPU. M1 is a secondary master, such as an
// interrupt-vector or debug loader.
//
// The arbiter puts one master's address phase on the shared bus. It also
// remembers which master owns the data phase in flight. That owner receives
// HREADY/HRDATA/HRESP, and the owner's write data drives HWDATA.
//
// Parameters
//   PARK_MASTER : master granted after reset and while nobody requests.
//   HOLD_MAX    : number of consecutive accepted address phases after which
//                 the owner counts as over-quota. The hold counter is 8 bits
//                 wide and saturates.
//
// Ports
//   HCLK, HRESETn        clock; synchronous active-low reset
//   Mx_HADDR/HTRANS/     per-master address phase (x = 0, 1)
//   HWRITE/HSIZE
//   Mx_HWDATA            per-master write data (data phase)
//   Mx_HREADY            per-master ready; 0 stalls the master
//   Mx_HRDATA, Mx_HRESP  per-master read data and error response
//   HADDR/HTRANS/        shared address phase to the decoder and slaves
//   HWRITE/HSIZE
//   HWDATA               shared write data
//   HREADY/HRDATA/HRESP  muxed slave response
//   GNT                  current address-phase owner (0 = M0, 1 = M1)
// -----------------------------------------------------------------------------
module sccomp_ahb_arbiter #(
  parameter bit          PARK_MASTER = 1'b0,
  parameter int unsigned HOLD_MAX    = 16
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  // master 0 (CPU)
  input  logic [31:0] M0_HADDR,
  input  logic [1:0]  M0_HTRANS,
  input  logic        M0_HWRITE,
  input  logic [2:0]  M0_HSIZE,
  input  logic [31:0] M0_HWDATA,
  output logic        M0_HREADY,
  output logic [31:0] M0_HRDATA,
  output logic        M0_HRESP,
  // master 1 (loader / debug)
  input  logic [31:0] M1_HADDR,
  input  logic [1:0]  M1_HTRANS,
  input  logic        M1_HWRITE,
  input  logic [2:0]  M1_HSIZE,
  input  logic [31:0] M1_HWDATA,
  output logic        M1_HREADY,
  output logic [31:0] M1_HRDATA,
  output logic        M1_HRESP,
  // shared bus
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [31:0] HWDATA,
  input  logic        HREADY,
  input  logic [31:0] HRDATA,
  input  logic        HRESP,
  output logic        GNT
);

  localparam logic [7:0] HOLD_LIMIT = 8'(HOLD_MAX);
  localparam logic [1:0] TRANS_IDLE = 2'b00;
  localparam logic [1:0] TRANS_NSEQ = 2'b10;

  // Registered state
  logic       gnt;       // address-phase owner
  logic       dp_valid;  // a data phase is in flight
  logic       dp_owner;  // master that owns that data phase
  logic [7:0] hold_cnt;  // consecutive accepted phases by the current owner

  logic       gnt_nxt;
  logic       dp_valid_nxt;
  logic       dp_owner_nxt;
  logic [7:0] hold_cnt_nxt;

  // Request decode. Encodings 01 and 11 count as NONSEQ.
  logic req0, req1;
  logic owner_req, other_req, over_quota;

  assign req0       = |M0_HTRANS;
  assign req1       = |M1_HTRANS;
  assign owner_req  = gnt ? req1 : req0;
  assign other_req  = gnt ? req0 : req1;
  assign over_quota = (hold_cnt >= HOLD_LIMIT);

  // Next-state logic. Grant changes only at an edge where the owner issues no
  // new address. The outgoing owner therefore never has an address phase that
  // overlaps the incoming owner's.
  //
  // With quota exhausted and nobody requesting, the grant is handed to the
  // other master ahead of time. If both masters then request together, the
  // former owner is already the non-granted one and waits.
  always_comb begin
    // NOTE: every output gets a default first, so no path through this
    // block leaves a variable unassigned and infers a latch.
    gnt_nxt      = gnt;
    dp_valid_nxt = dp_valid;
    dp_owner_nxt = dp_owner;
    hold_cnt_nxt = hold_cnt;

    // HREADY low: all state holds.
    if (HREADY) begin
      if (owner_req) begin
        dp_valid_nxt = 1'b1;
        dp_owner_nxt = gnt;
        hold_cnt_nxt = (hold_cnt == 8'hFF) ? hold_cnt : hold_cnt + 8'd1;
      end else begin
        dp_valid_nxt = 1'b0;
        if (other_req || over_quota) begin
          gnt_nxt      = ~gnt;
          hold_cnt_nxt = 8'd0;
        end else if (gnt != PARK_MASTER) begin
          gnt_nxt      = PARK_MASTER;
          hold_cnt_nxt = 8'd0;
        end
      end
    end
  end

  // State register. Reset abandons any data phase in flight.
  always_ff @(posedge HCLK) begin
    // NOTE: sequential state uses non-blocking assignments, so every
    // register samples pre-edge values regardless of statement order.
    if (!HRESETn) begin
      gnt      <= PARK_MASTER;
      dp_valid <= 1'b0;
      dp_owner <= PARK_MASTER;
      hold_cnt <= 8'd0;
    end else begin
      gnt      <= gnt_nxt;
      dp_valid <= dp_valid_nxt;
      dp_owner <= dp_owner_nxt;
      hold_cnt <= hold_cnt_nxt;
    end
  end

  // Address-phase mux. HTRANS is normalised to NONSEQ or IDLE.
  always_comb begin
    HADDR  = gnt ? M1_HADDR  : M0_HADDR;
    HWRITE = gnt ? M1_HWRITE : M0_HWRITE;
    HSIZE  = gnt ? M1_HSIZE  : M0_HSIZE;
    HTRANS = owner_req ? TRANS_NSEQ : TRANS_IDLE;
  end

  // Data-phase routing
  logic dp_is_m0, dp_is_m1;

  assign dp_is_m0 = dp_valid && (dp_owner == 1'b0);
  assign dp_is_m1 = dp_valid && (dp_owner == 1'b1);

  always_comb begin
    HWDATA    = 32'd0;
    M0_HRDATA = 32'd0;
    M0_HRESP  = 1'b0;
    M1_HRDATA = 32'd0;
    M1_HRESP  = 1'b0;

    if (dp_valid) HWDATA = dp_owner ? M1_HWDATA : M0_HWDATA;

    if (dp_is_m0) begin
      M0_HRDATA = HRDATA;
      M0_HRESP  = HRESP;
    end
    if (dp_is_m1) begin
      M1_HRDATA = HRDATA;
      M1_HRESP  = HRESP;
    end
  end

  // Per-master ready. Rules in priority order:
  //   1. the data-phase owner follows the slave;
  //   2. a requesting non-granted master is stalled so it holds its address;
  //   3. the granted master follows the slave, because its address is on
  //      the bus;
  //   4. any other master sees ready.
  always_comb begin
    M0_HREADY = 1'b1;
    M1_HREADY = 1'b1;

    if (dp_is_m0)                M0_HREADY = HREADY;
    else if (gnt != 1'b0 && req0) M0_HREADY = 1'b0;
    else if (gnt == 1'b0)         M0_HREADY = HREADY;

    if (dp_is_m1)                M1_HREADY = HREADY;
    else if (gnt != 1'b1 && req1) M1_HREADY = 1'b0;
    else if (gnt == 1'b1)         M1_HREADY = HREADY;
  end

  assign GNT = gnt;

endmodule

// File: tb/tb_sccomp_ahb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sccomp_ahb_arbiter
//
// Directed bench for sccomp_ahb_arbiter, built with PARK_MASTER=0 and
// HOLD_MAX=4. Inputs change 1 ns after each rising edge. Outputs are sampled
// 1 ns after that, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_sccomp_ahb_arbiter;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic [31:0] m0_haddr, m1_haddr;
  logic [1:0]  m0_htrans, m1_htrans;
  logic        m0_hwrite, m1_hwrite;
  logic [2:0]  m0_hsize, m1_hsize;
  logic [31:0] m0_hwdata, m1_hwdata;
  logic        m0_hready, m1_hready;
  logic [31:0] m0_hrdata, m1_hrdata;
  logic        m0_hresp, m1_hresp;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        hready;
  logic [31:0] hrdata;
  logic        hresp;
  logic        gnt;

  int checks = 0;
  int errors = 0;

  always #5 hclk = ~hclk;

  sccomp_ahb_arbiter #(
    .PARK_MASTER (1'b0),
    .HOLD_MAX    (4)
  ) dut (
    .HCLK      (hclk),
    .HRESETn   (hresetn),
    .M0_HADDR  (m0_haddr),
    .M0_HTRANS (m0_htrans),
    .M0_HWRITE (m0_hwrite),
    .M0_HSIZE  (m0_hsize),
    .M0_HWDATA (m0_hwdata),
    .M0_HREADY (m0_hready),
    .M0_HRDATA (m0_hrdata),
    .M0_HRESP  (m0_hresp),
    .M1_HADDR  (m1_haddr),
    .M1_HTRANS (m1_htrans),
    .M1_HWRITE (m1_hwrite),
    .M1_HSIZE  (m1_hsize),
    .M1_HWDATA (m1_hwdata),
    .M1_HREADY (m1_hready),
    .M1_HRDATA (m1_hrdata),
    .M1_HRESP  (m1_hresp),
    .HADDR     (haddr),
    .HTRANS    (htrans),
    .HWRITE    (hwrite),
    .HSIZE     (hsize),
    .HWDATA    (hwdata),
    .HREADY    (hready),
    .HRDATA    (hrdata),
    .HRESP     (hresp),
    .GNT       (gnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to 1 ns past the next rising edge.
  task automatic cyc();
    @(posedge hclk);
    #1;
  endtask

  initial begin
    hresetn   = 1'b0;
    m0_haddr  = '0; m0_htrans = 2'b00; m0_hwrite = 1'b0; m0_hsize = 3'd2; m0_hwdata = '0;
    m1_haddr  = '0; m1_htrans = 2'b00; m1_hwrite = 1'b0; m1_hsize = 3'd2; m1_hwdata = '0;
    hready    = 1'b1; hrdata = '0; hresp = 1'b0;

    // Reset
    cyc(); cyc();
    hresetn = 1'b1;
    #1;
    check("rst_htrans",   32'(htrans),    32'd0);
    check("rst_gnt",      32'(gnt),       32'd0);
    check("rst_m0_ready", 32'(m0_hready), 32'd1);
    check("rst_m1_ready", 32'(m1_hready), 32'd1);
    check("rst_m0_rdata", m0_hrdata,      32'd0);
    check("rst_m1_rdata", m1_hrdata,      32'd0);
    check("rst_m0_resp",  32'(m0_hresp),  32'd0);
    check("rst_hwdata",   hwdata,         32'd0);

    // Single M0 read
    m0_htrans = 2'b10; m0_haddr = 32'h8000_0010; m0_hwrite = 1'b0;
    #1;
    check("rd_haddr",  haddr,        32'h8000_0010);
    check("rd_htrans", 32'(htrans),  32'd2);
    check("rd_gnt",    32'(gnt),     32'd0);
    cyc();
    m0_htrans = 2'b00; hrdata = 32'h1234_5678;
    #1;
    check("rd_m0_rdata", m0_hrdata,      32'h1234_5678);
    check("rd_m1_rdata", m1_hrdata,      32'd0);
    check("rd_m1_ready", 32'(m1_hready), 32'd1);
    check("rd_gnt_dp",   32'(gnt),       32'd0);
    cyc();
    hrdata = '0;
    #1;
    // Under quota: an idle owner with no competitor keeps the parked grant.
    check("park_gnt", 32'(gnt), 32'd0);

    // M0 streams four writes while M1 waits on 0xBF800000
    m1_htrans = 2'b10; m1_haddr = 32'hBF80_0000; m1_hwrite = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        m0_htrans = 2'b10; m0_haddr = 32'h100 + 32'(4 * i); m0_hwrite = 1'b1;
      end else begin
        m0_htrans = 2'b00;
      end
      if (i > 0) m0_hwdata = 32'hD000_0000 + 32'(i - 1);
      #1;
      check("wr_m1_stall", 32'(m1_hready), 32'd0);
      check("wr_gnt",      32'(gnt),       32'd0);
      if (i < 4) check("wr_haddr", haddr, 32'h100 + 32'(4 * i));
      if (i > 0) check("wr_hwdata", hwdata, 32'hD000_0000 + 32'(i - 1));
      cyc();
    end
    m0_hwdata = '0;
    #1;
    check("ho_gnt",      32'(gnt),       32'd1);
    check("ho_haddr",    haddr,          32'hBF80_0000);
    check("ho_htrans",   32'(htrans),    32'd2);
    check("ho_m1_ready", 32'(m1_hready), 32'd1);
    check("ho_m0_ready", 32'(m0_hready), 32'd1);
    check("ho_hwdata",   hwdata,         32'd0);
    cyc();

    // Two slave wait states during M1's data phase. HRESP passes through.
    m1_htrans = 2'b00; hready = 1'b0; hrdata = 32'hCAFE_F00D; hresp = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("ws_m1_ready", 32'(m1_hready), 32'd0);
      check("ws_m0_ready", 32'(m0_hready), 32'd1);
      check("ws_gnt",      32'(gnt),       32'd1);
      check("ws_haddr",    haddr,          32'hBF80_0000);
      check("ws_htrans",   32'(htrans),    32'd0);
      check("ws_m1_rdata", m1_hrdata,      32'hCAFE_F00D);
      check("ws_m1_resp",  32'(m1_hresp),  32'd1);
      check("ws_m0_resp",  32'(m0_hresp),  32'd0);
      cyc();
    end
    hready = 1'b1; hresp = 1'b0;
    #1;
    check("ws_done_ready", 32'(m1_hready), 32'd1);
    check("ws_done_rdata", m1_hrdata,      32'hCAFE_F00D);
    check("ws_done_gnt",   32'(gnt),       32'd1);
    cyc();
    hrdata = '0;
    #1;
    // Both idle: the grant returns to the park master.
    check("repark_gnt",    32'(gnt),    32'd0);
    check("repark_htrans", 32'(htrans), 32'd0);
    check("repark_rdata",  m1_hrdata,   32'd0);

    // Quota: five back-to-back M0 transfers, one idle cycle, then both request
    for (int i = 0; i < 5; i++) begin
      m0_htrans = 2'b10; m0_haddr = 32'h200 + 32'(4 * i); m0_hwrite = 1'b0;
      #1;
      check("q_gnt_m0", 32'(gnt), 32'd0);
      cyc();
    end
    m0_htrans = 2'b00;
    #1;
    check("q_idle_gnt", 32'(gnt),          32'd0);
    check("q_hold_cnt", 32'(dut.hold_cnt), 32'd5);
    cyc();
    m0_htrans = 2'b10; m0_haddr = 32'h300;
    m1_htrans = 2'b10; m1_haddr = 32'hBF80_0004;
    #1;
    check("q_gnt_m1",      32'(gnt),          32'd1);
    check("q_hold_clr",    32'(dut.hold_cnt), 32'd0);
    check("q_m0_stall",    32'(m0_hready),    32'd0);
    check("q_m1_ready",    32'(m1_hready),    32'd1);
    check("q_haddr",       haddr,             32'hBF80_0004);
    cyc();
    m1_htrans = 2'b00;
    #1;
    check("q_m0_wait",     32'(m0_hready),    32'd0);
    cyc();
    #1;
    check("q_back_gnt",    32'(gnt),          32'd0);
    check("q_back_haddr",  haddr,             32'h300);
    check("q_back_ready",  32'(m0_hready),    32'd1);

    // Reset asserted during a stalled M1 data phase
    m1_htrans = 2'b10; m1_haddr = 32'hBF80_0008;
    cyc();
    m0_htrans = 2'b00;
    #1;
    check("r_m1_stall", 32'(m1_hready), 32'd0);
    cyc();
    #1;
    check("r_gnt_m1",   32'(gnt),       32'd1);
    cyc();
    m1_htrans = 2'b00; hready = 1'b0; hrdata = 32'h55AA_55AA;
    #1;
    check("r_dp_rdata", m1_hrdata,      32'h55AA_55AA);
    check("r_dp_ready", 32'(m1_hready), 32'd0);
    hresetn = 1'b0;
    cyc();
    hresetn = 1'b1; hready = 1'b1;
    #1;
    check("r_htrans",   32'(htrans),    32'd0);
    check("r_gnt",      32'(gnt),       32'd0);
    check("r_m0_ready", 32'(m0_hready), 32'd1);
    check("r_m1_ready", 32'(m1_hready), 32'd1);
    check("r_m1_rdata", m1_hrdata,      32'd0);
    check("r_hwdata",   hwdata,         32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sccomp_ahb_arbiter.md
Name: sccomp_ahb_arbiter

Overview:
- Two-master AHB-Lite arbiter in front of the shared address decoder and slave bus of the single-cycle interrupt-capable system.
- M0 is the CPU. M1 is a secondary master (interrupt-vector / debug loader).
- The arbiter selects one master's address phase onto the shared HADDR/HTRANS/HWRITE/HSIZE, which feeds the decoder.
- It tracks the data-phase owner, routing HWDATA to the bus and HREADY/HRDATA/HRESP back to the correct master.

Parameters:
- PARK_MASTER, 0, master granted after reset and when no one requests (0 or 1).
- HOLD_MAX, 16, max consecutive accepted NONSEQ address phases by one owner before it is marked "over-quota"; the other requester then wins the next handover; 8-bit counter saturates.

Ports:
- HCLK  input  1  system clock.
- HRESETn  input  1  synchronous active-low reset.
- M0_HADDR, M1_HADDR  input  32  master address.
- M0_HTRANS, M1_HTRANS  input  2  00 IDLE, 10 NONSEQ (01/11 treated as NONSEQ).
- M0_HWRITE, M1_HWRITE  input  1  write.
- M0_HSIZE, M1_HSIZE  input  3  size.
- M0_HWDATA, M1_HWDATA  input  32  write data (data phase).
- M0_HREADY, M1_HREADY  output  1  per-master ready/stall.
- M0_HRDATA, M1_HRDATA  output  32  read data.
- M0_HRESP, M1_HRESP  output  1  error response.
- HADDR  output  32  shared address to decoder/slaves.
- HTRANS  output  2  shared transfer type.
- HWRITE  output  1  shared write.
- HSIZE  output  3  shared size.
- HWDATA  output  32  shared write data.
- HREADY  input  1  muxed slave ready.
- HRDATA  input  32  muxed slave read data.
- HRESP  input  1  muxed slave error.
- GNT  output  1  current address-phase owner (0=M0, 1=M1).

Behaviour:
- State: gnt (1b), dp_valid (1b), dp_owner (1b), hold_cnt (8b). All registers update only on HCLK rising edge.
- Reset (HRESETn=0 at edge): gnt=PARK_MASTER, dp_valid=0, dp_owner=PARK_MASTER, hold_cnt=0. Resulting outputs: HTRANS=00, GNT=PARK_MASTER, both Mx_HREADY=1, Mx_HRESP=0, Mx_HRDATA=0. Reset mid-transfer abandons the data phase with no completion signalled.
- Address mux (combinational): HADDR/HWRITE/HSIZE/HTRANS come from master gnt. HTRANS is forced to 00 while the granted master drives IDLE.
- Address accepted: HREADY=1 and the granted master's HTRANS≠00. At that edge: dp_valid<=1, dp_owner<=gnt, hold_cnt<=sat(hold_cnt+1).
- When HREADY=1 and no address is accepted: dp_valid<=0.
- HREADY=0: dp_valid, dp_owner and hold_cnt hold.
- Handover: only at an edge with HREADY=1 where the owner drives IDLE and the other master drives NONSEQ. Then gnt<=other and hold_cnt<=0.
  - Rationale: the owner has no new data phase, so there is no data-phase/address-phase conflict across the switch.
- Both request from park (owner idle, other requesting): switch as above.
- Quota: if hold_cnt≥HOLD_MAX, the owner is idle that edge, and both masters' requests are pending next cycle, the non-owner wins the switch. Otherwise, an idle owner that then requests keeps the grant only if the other is not requesting.
- No requests: gnt returns to PARK_MASTER at the next HREADY=1 edge.
- Mx_HREADY:
  - Master with dp_valid and dp_owner=x: HREADY.
  - Non-granted master driving NONSEQ: 0 (stalled, must hold its address).
  - Granted master: HREADY.
  - Otherwise: 1.
- Read response: Mx_HRDATA=HRDATA and Mx_HRESP=HRESP when dp_valid and dp_owner=x, else 0.
- HWDATA: M{dp_owner}_HWDATA when dp_valid, else 0.
- Latency: zero added cycles for the owner. A non-owner waits ≥1 cycle after the owner idles.
- Error: HRESP is forwarded unchanged; the arbiter does not cancel transfers on error.

Test Plan:
- Reset, then M0 read of 0x80000010 with HRDATA=0x12345678, HREADY=1 → HADDR=0x80000010 and HTRANS=10 same cycle; next cycle M0_HRDATA=0x12345678, M1_HREADY=1, GNT=0.
- M0 streaming 4 NONSEQ writes while M1 requests 0xBF800000 → M1_HREADY=0 for all 4 cycles plus the idle cycle. After M0 drives IDLE: GNT=1, HADDR=0xBF800000. M0 write data reaches HWDATA in each data phase.
- Slave wait state: HREADY=0 for 2 cycles during M1 data phase → M1_HREADY=0 for 2 cycles; GNT, HADDR and dp_owner stable; completes on cycle 3.
- Quota with HOLD_MAX=4: M0 issues 5 transfers, idles 1 cycle, then re-requests while M1 requests → GNT=1 and hold_cnt=0.
- HRESETn=0 asserted during an M1 data phase with HREADY=0 → next cycle HTRANS=00, GNT=PARK_MASTER, both Mx_HREADY=1, M1_HRDATA=0.
- Both idle after M1 ownership, PARK_MASTER=0 → GNT returns to 0 at the next HREADY=1 edge; HTRANS=00 throughout.
